load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface, located in the Memory stage. It takes a load/store request from the pipeline and runs it as one or two word-aligned transactions on a byte-enabled req/ack data bus. Accesses that cross a word boundary are split into two transactions. It assembles and sign- or zero-extends load data, and holds the pipeline with Stall until the access completes.

Parameters:
ALLOW_SPLIT, 1, 1 = split word-crossing accesses into two beats; 0 = reject them with Misaligned and issue no bus transaction.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST_N  input  1  asynchronous, active-low reset.
MEM_Req  input  1  pipeline has a load/store in the Memory stage.
MEM_W_En  input  1  1 = store, 0 = load.
MEM_Control  input  3  access size/sign; encodings from the definitions package (MEM_BYTE, MEM_BYTE_UNSIGNED, MEM_HALFWORD, MEM_HALFWORD_UNSIGNED, MEM_WORD).
Addr  input  32  byte address (ALU_Out_M).
W_Data  input  32  store data, right-aligned.
Stall  output  1  hold the pipeline; the Memory-stage inputs stay stable while this is high.
Done  output  1  one-cycle completion pulse.
R_Data  output  32  extended load result; valid when Done=1, held until the next Done.
Misaligned  output  1  one-cycle pulse with Done when a split is rejected (ALLOW_SPLIT=0).
BUS_Req  output  1  transaction request.
BUS_W_En  output  1  transaction is a write.
BUS_Addr  output  32  word-aligned address; bits [1:0] are always 0.
BUS_Byte_En  output  4  active byte lanes.
BUS_W_Data  output  32  lane-aligned write data.
BUS_R_Data  input  32  read data; valid in the BUS_Ack cycle.
BUS_Ack  input  1  responder completes the current beat.

Behaviour:
- Reset (async, RST_N=0): state goes to IDLE. Every output is 0: Stall, Done, R_Data, Misaligned, BUS_Req, BUS_W_En, BUS_Addr, BUS_Byte_En, BUS_W_Data.
- Reset mid-transaction: BUS_Req drops immediately and the beat is abandoned. The responder must tolerate this.
- States: IDLE, BEAT1, BEAT2, DONE.
- IDLE:
  - MEM_Req=1 with a valid control: latch the inputs and go to BEAT1.
  - MEM_Req=1 with an invalid control, or a rejected split: go to DONE with no bus activity. R_Data = 0; Misaligned = 1 only for the rejected split.
- BEAT1: drive beat 1. On BUS_Ack, go to BEAT2 if split, otherwise go to DONE.
- BEAT2: drive beat 2. On BUS_Ack, go to DONE.
- DONE: Done=1, Stall=0, then go to IDLE. No new request is accepted in this cycle.
- Stall = (state is BEAT1 or BEAT2) OR (state is IDLE AND MEM_Req). It is combinational from state and MEM_Req.
- Bus handshake:
  - BUS_Req is registered and stays high with all BUS_* signals stable until BUS_Ack is sampled high.
  - Ack in the first Req cycle is legal (zero-wait responder).
  - BUS_Ack while BUS_Req=0 is ignored.
  - BUS_Req is low for at least one cycle between the beats of a split.
- Lane math. Definitions:
  - o = Addr[1:0].
  - n = 1, 2 or 4 bytes; m = (1<<n)-1.
  - split = (o+n > 4).
- Beat 1:
  - BUS_Addr = {Addr[31:2], 2'b00}.
  - BUS_Byte_En = (m<<o)[3:0].
  - BUS_W_Data = W_Data << 8o.
- Beat 2:
  - BUS_Addr = beat-1 address + 4, wrapping modulo 2^32.
  - BUS_Byte_En = m >> (4-o).
  - BUS_W_Data = W_Data >> 8(4-o).
- Load assembly:
  - raw = (D1 >> 8o) | (split ? D2 << 8(4-o) : 0).
  - Extend raw according to MEM_Control: byte/halfword signed or unsigned; word passes through.
- Latency: an aligned access with a zero-wait responder completes in 3 cycles, from accept to the Done pulse inclusive. A split access adds 2 cycles plus any wait states.
- Little-endian throughout.

Decomposition:
- Add to the definitions package: an lsu_state_t enum (IDLE, BEAT1, BEAT2, DONE) and a size_bytes(MEM_Control) function.
- The MEM_* encodings already live in that package.
- One sub-module, lsu_lane_align: purely combinational. It computes Byte_En and W_Data shifts and the load merge/extend. It is unit-testable on its own.

Test Plan:
- SW of 0xDEADBEEF to 0x100, zero-wait: one beat with Addr 0x100, Byte_En 1111, W_Data 0xDEADBEEF. Done pulses in the 3rd cycle and Stall is high for 2 cycles.
- LB at 0x43 with BUS_R_Data 0x80123456: Byte_En 1000 and R_Data 0xFFFFFF80. The same access as LBU gives R_Data 0x00000080.
- SW of 0xDEADBEEF to 0x102: beat 1 is 0x100 / 1100 / 0xBEEF0000; beat 2 is 0x104 / 0011 / 0x0000DEAD. BUS_Req drops for one cycle between the beats.
- LH at 0xFF with D1=0xAB000000 and D2=0x000000CD: beats go to 0xFC and 0x100, and R_Data = 0xFFFFCDAB.
- LW at 0xFFFFFFFE: beat 2 address wraps to 0x00000000. Inserting 3 wait cycles per beat keeps all BUS_* signals stable while Stall stays high.
- Remaining edge cases:
  - With ALLOW_SPLIT=0, a word access at 0x101 causes no BUS_Req, pulses Done and Misaligned, and gives R_Data=0.
  - An invalid MEM_Control gives R_Data=0.
  - Asserting RST_N=0 during BEAT1 drops BUS_Req asynchronously and clears all outputs to 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-memory load/store path: access encodings, FSM states, size decode.
package load_store_unit_pkg;

    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    // Access width in bytes; 0 flags an encoding the unit does not support.
    function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
        case (ctrl)
            MEM_BYTE, MEM_BYTE_UNSIGNED:         size_bytes = 3'd1;
            MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: size_bytes = 3'd2;
            MEM_WORD:                            size_bytes = 3'd4;
            default:                             size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned, byte-enabled req/ack data bus; master is the load/store unit, slave the memory responder.
interface load_store_unit_if;
    logic        BUS_Req;
    logic        BUS_W_En;
    logic [31:0] BUS_Addr;
    logic [3:0]  BUS_Byte_En;
    logic [31:0] BUS_W_Data;
    logic [31:0] BUS_R_Data;
    logic        BUS_Ack;

    modport master (
        output BUS_Req, BUS_W_En, BUS_Addr, BUS_Byte_En, BUS_W_Data,
        input  BUS_R_Data, BUS_Ack
    );

    modport slave (
        input  BUS_Req, BUS_W_En, BUS_Addr, BUS_Byte_En, BUS_W_Data,
        output BUS_R_Data, BUS_Ack
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering for both beats of an access plus little-endian load merge and sign/zero extension.
// Latency: purely combinational; backpressure: none.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  Offset,
    input  logic [2:0]  Control,
    input  logic [31:0] W_Data,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Valid,
    output logic        Split,
    output logic [3:0]  Byte_En_1,
    output logic [3:0]  Byte_En_2,
    output logic [31:0] W_Data_1,
    output logic [31:0] W_Data_2,
    output logic [31:0] R_Data
);

    logic [2:0]  size;
    logic [3:0]  mask;
    logic [5:0]  sh;
    logic [31:0] raw;

    always_comb begin
        size  = size_bytes(Control);
        Valid = (size != 3'd0);
        Split = ({2'b00, Offset} + {1'b0, size}) > 4'd4;

        case (size)
            3'd1:    mask = 4'h1;
            3'd2:    mask = 4'h3;
            3'd4:    mask = 4'hF;
            default: mask = 4'h0;
        endcase

        // Shifts by 32 yield zero, which is exactly the empty second beat of an aligned access.
        sh        = {1'b0, Offset, 3'b000};
        Byte_En_1 = mask << Offset;
        Byte_En_2 = mask >> (3'd4 - {1'b0, Offset});
        W_Data_1  = W_Data << sh;
        W_Data_2  = W_Data >> (6'd32 - sh);

        raw = (D1 >> sh) | (Split ? (D2 << (6'd32 - sh)) : 32'd0);

        case (Control)
            MEM_BYTE:              R_Data = {{24{raw[7]}}, raw[7:0]};
            MEM_BYTE_UNSIGNED:     R_Data = {24'd0, raw[7:0]};
            MEM_HALFWORD:          R_Data = {{16{raw[15]}}, raw[15:0]};
            MEM_HALFWORD_UNSIGNED: R_Data = {16'd0, raw[15:0]};
            MEM_WORD:              R_Data = raw;
            default:               R_Data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: runs each access as one or two word-aligned req/ack beats.
// Latency: 3 cycles aligned zero-wait, +2 for a split, +wait states; Stall holds the pipeline throughout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     MEM_Req,
    input  logic                     MEM_W_En,
    input  logic [2:0]               MEM_Control,
    input  logic [31:0]              Addr,
    input  logic [31:0]              W_Data,
    output logic                     Stall,
    output logic                     Done,
    output logic [31:0]              R_Data,
    output logic                     Misaligned,
    load_store_unit_if.master        bus
);

    lsu_state_t  state_q, state_d;

    logic        w_en_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] d1_q;
    logic [31:0] r_data_q;
    logic        misal_q;

    logic        bus_req_q;
    logic        bus_w_en_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        in_idle;
    logic [1:0]  la_off;
    logic [2:0]  la_ctrl;
    logic [31:0] la_wdata;
    logic [31:0] la_d1;
    logic        la_valid;
    logic        la_split;
    logic [3:0]  la_be1, la_be2;
    logic [31:0] la_wd1, la_wd2;
    logic [31:0] la_r_data;
    logic        reject_split;
    logic        accept;
    logic        beat_ack;

    // In IDLE the lane math runs on the live request so beat 1 can be registered at accept.
    assign in_idle      = (state_q == IDLE);
    assign la_off       = in_idle ? Addr[1:0]   : off_q;
    assign la_ctrl      = in_idle ? MEM_Control : ctrl_q;
    assign la_wdata     = in_idle ? W_Data      : wdata_q;
    assign la_d1        = (state_q == BEAT1) ? bus.BUS_R_Data : d1_q;
    assign reject_split = la_valid && la_split && (ALLOW_SPLIT == 1'b0);
    assign accept       = MEM_Req && la_valid && !reject_split;
    assign beat_ack     = bus_req_q && bus.BUS_Ack;

    lsu_lane_align u_lane_align (
        .Offset    (la_off),
        .Control   (la_ctrl),
        .W_Data    (la_wdata),
        .D1        (la_d1),
        .D2        (bus.BUS_R_Data),
        .Valid     (la_valid),
        .Split     (la_split),
        .Byte_En_1 (la_be1),
        .Byte_En_2 (la_be2),
        .W_Data_1  (la_wd1),
        .W_Data_2  (la_wd2),
        .R_Data    (la_r_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (MEM_Req) state_d = accept ? BEAT1 : DONE;
            BEAT1: if (beat_ack) state_d = la_split ? BEAT2 : DONE;
            BEAT2: if (beat_ack) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is forced low under reset so every output reads zero while RST_N is asserted.
    always_comb begin
        Stall      = RST_N && ((state_q == BEAT1) || (state_q == BEAT2) || (in_idle && MEM_Req));
        Done       = (state_q == DONE);
        Misaligned = (state_q == DONE) && misal_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_en_q      <= 1'b0;
            ctrl_q      <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 32'd0;
            d1_q        <= 32'd0;
            r_data_q    <= 32'd0;
            misal_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_w_en_q  <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (MEM_Req) begin
                    w_en_q  <= MEM_W_En;
                    ctrl_q  <= MEM_Control;
                    off_q   <= Addr[1:0];
                    wdata_q <= W_Data;
                    misal_q <= reject_split;
                    if (accept) begin
                        bus_req_q   <= 1'b1;
                        bus_w_en_q  <= MEM_W_En;
                        bus_addr_q  <= {Addr[31:2], 2'b00};
                        bus_be_q    <= la_be1;
                        bus_wdata_q <= la_wd1;
                    end else begin
                        r_data_q <= 32'd0;
                    end
                end
                BEAT1: if (beat_ack) begin
                    bus_req_q <= 1'b0;
                    d1_q      <= bus.BUS_R_Data;
                    if (!la_split && !w_en_q) r_data_q <= la_r_data;
                end
                // First BEAT2 cycle is the mandatory idle gap; beat 2 is launched from it.
                BEAT2: if (!bus_req_q) begin
                    bus_req_q   <= 1'b1;
                    bus_addr_q  <= bus_addr_q + 32'd4;
                    bus_be_q    <= la_be2;
                    bus_wdata_q <= la_wd2;
                end else if (bus.BUS_Ack) begin
                    bus_req_q <= 1'b0;
                    if (!w_en_q) r_data_q <= la_r_data;
                end
                default: ;
            endcase
        end
    end

    assign R_Data          = r_data_q;
    assign bus.BUS_Req     = bus_req_q;
    assign bus.BUS_W_En    = bus_w_en_q;
    assign bus.BUS_Addr    = bus_addr_q;
    assign bus.BUS_Byte_En = bus_be_q;
    assign bus.BUS_W_Data  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table with a behavioural bus responder, plus
// hand sequences for rejected splits (ALLOW_SPLIT=0) and reset in the middle of a beat.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        MEM_Req = 1'b0;
    logic        MEM_Req2 = 1'b0;
    logic        MEM_W_En = 1'b0;
    logic [2:0]  MEM_Control = 3'd0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] W_Data = 32'd0;
    logic        Stall, Done, Misaligned;
    logic [31:0] R_Data;
    logic        Stall2, Done2, Misaligned2;
    logic [31:0] R_Data2;

    load_store_unit_if bus();
    load_store_unit_if bus2();

    always #5 CLK = ~CLK;

    load_store_unit #(.ALLOW_SPLIT(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .MEM_Req(MEM_Req), .MEM_W_En(MEM_W_En),
        .MEM_Control(MEM_Control), .Addr(Addr), .W_Data(W_Data),
        .Stall(Stall), .Done(Done), .R_Data(R_Data), .Misaligned(Misaligned),
        .bus(bus)
    );

    load_store_unit #(.ALLOW_SPLIT(1'b0)) dut_nosplit (
        .CLK(CLK), .RST_N(RST_N), .MEM_Req(MEM_Req2), .MEM_W_En(MEM_W_En),
        .MEM_Control(MEM_Control), .Addr(Addr), .W_Data(W_Data),
        .Stall(Stall2), .Done(Done2), .R_Data(R_Data2), .Misaligned(Misaligned2),
        .bus(bus2)
    );

    typedef struct {
        logic        w_en;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] d1;
        logic [31:0] d2;
        int          waits;
        logic        spur;
        int          nb;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic [31:0] rdata;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    int n_cmp = 0;
    int n_bad = 0;

    int          r_done_cyc, r_stall, r_nb, r_gap, r_unstable;
    logic        r_stall_done, r_mis;
    logic [31:0] r_rdata;
    logic [31:0] r_a[2];
    logic [3:0]  r_be[2];
    logic [31:0] r_wd[2];
    logic        r_we[2];

    function automatic vec_t mk(input logic w_en, input logic [2:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] d1, input logic [31:0] d2,
                                input int waits, input logic spur, input int nb,
                                input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                                input logic [31:0] a2, input logic [3:0] be2, input logic [31:0] wd2,
                                input logic [31:0] rdata, input int cyc);
        vec_t v;
        v.w_en = w_en; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.d1 = d1; v.d2 = d2;
        v.waits = waits; v.spur = spur; v.nb = nb;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.a2 = a2; v.be2 = be2; v.wd2 = wd2;
        v.rdata = rdata; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string p);
        chk({p, " Stall"},       32'(Stall), 32'd0);
        chk({p, " Done"},        32'(Done), 32'd0);
        chk({p, " R_Data"},      R_Data, 32'd0);
        chk({p, " Misaligned"},  32'(Misaligned), 32'd0);
        chk({p, " BUS_Req"},     32'(bus.BUS_Req), 32'd0);
        chk({p, " BUS_W_En"},    32'(bus.BUS_W_En), 32'd0);
        chk({p, " BUS_Addr"},    bus.BUS_Addr, 32'd0);
        chk({p, " BUS_Byte_En"}, 32'(bus.BUS_Byte_En), 32'd0);
        chk({p, " BUS_W_Data"},  bus.BUS_W_Data, 32'd0);
    endtask

    // Drives one request and plays the responder: ack after v.waits wait cycles per beat,
    // optional spurious ack whenever BUS_Req is low. Bounded at 40 cycles.
    task automatic run_access(input vec_t v);
        int   wcnt;
        logic prev_req;
        r_done_cyc = 0; r_stall = 0; r_nb = 0; r_gap = 0; r_unstable = 0;
        r_stall_done = 1'b1; r_mis = 1'b0; r_rdata = 32'd0;
        for (int k = 0; k < 2; k++) begin
            r_a[k] = 32'd0; r_be[k] = 4'd0; r_wd[k] = 32'd0; r_we[k] = 1'b0;
        end
        prev_req = 1'b0;
        wcnt = 0;
        @(negedge CLK); #1;
        MEM_Req = 1'b1; MEM_W_En = v.w_en; MEM_Control = v.ctrl; Addr = v.addr; W_Data = v.wdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            #1;
            if (Done) begin
                r_done_cyc = cyc; r_rdata = R_Data; r_mis = Misaligned; r_stall_done = Stall;
                break;
            end
            if (Stall) r_stall++;
            if (bus.BUS_Req) begin
                if (!prev_req) begin
                    if (r_nb < 2) begin
                        r_a[r_nb] = bus.BUS_Addr; r_be[r_nb] = bus.BUS_Byte_En;
                        r_wd[r_nb] = bus.BUS_W_Data; r_we[r_nb] = bus.BUS_W_En;
                    end
                    r_nb++;
                    wcnt = 0;
                end else if (r_nb <= 2) begin
                    if (bus.BUS_Addr !== r_a[r_nb-1] || bus.BUS_Byte_En !== r_be[r_nb-1] ||
                        bus.BUS_W_Data !== r_wd[r_nb-1] || bus.BUS_W_En !== r_we[r_nb-1])
                        r_unstable++;
                end
                bus.BUS_Ack = (wcnt == v.waits);
                bus.BUS_R_Data = (r_nb == 1) ? v.d1 : v.d2;
                wcnt++;
            end else begin
                if (r_nb == 1) r_gap++;
                bus.BUS_Ack = v.spur;
                bus.BUS_R_Data = 32'hBAD0_BAD0;
            end
            prev_req = bus.BUS_Req;
            @(negedge CLK);
        end
        MEM_Req = 1'b0;
        bus.BUS_Ack = 1'b0;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        chk({p, " done_cycle"},     32'(r_done_cyc), 32'(v.cyc));
        chk({p, " stall_cycles"},   32'(r_stall), 32'(v.cyc - 1));
        chk({p, " stall_in_done"},  32'(r_stall_done), 32'd0);
        chk({p, " beats"},          32'(r_nb), 32'(v.nb));
        chk({p, " misaligned"},     32'(r_mis), 32'd0);
        if (v.nb >= 1) begin
            chk({p, " b1_addr"},  r_a[0], v.a1);
            chk({p, " b1_be"},    32'(r_be[0]), 32'(v.be1));
            chk({p, " b1_wdata"}, r_wd[0], v.wd1);
            chk({p, " b1_wen"},   32'(r_we[0]), 32'(v.w_en));
            chk({p, " stable"},   32'(r_unstable), 32'd0);
        end
        if (v.nb == 2) begin
            chk({p, " b2_addr"},  r_a[1], v.a2);
            chk({p, " b2_be"},    32'(r_be[1]), 32'(v.be2));
            chk({p, " b2_wdata"}, r_wd[1], v.wd2);
            chk({p, " gap"},      32'(r_gap), 32'd1);
        end
        if (!v.w_en) chk({p, " r_data"}, r_rdata, v.rdata);
        @(negedge CLK); #2;
        chk({p, " done_pulse"}, 32'(Done), 32'd0);
        chk({p, " idle_stall"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        bus.BUS_Ack = 1'b0;  bus.BUS_R_Data = 32'd0;
        bus2.BUS_Ack = 1'b0; bus2.BUS_R_Data = 32'd0;

        //            we    ctrl                   addr          wdata         d1            d2            w  sp nb a1            be1      wd1           a2            be2      wd2           rdata         cyc
        vecs[0]  = mk(1'b1, MEM_WORD,              32'h100,      32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 1, 32'h100,      4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0,        32'h0,        3);
        vecs[1]  = mk(1'b0, MEM_BYTE,              32'h43,       32'h0,        32'h80123456, 32'h0,        0, 0, 1, 32'h40,       4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 3);
        vecs[2]  = mk(1'b0, MEM_BYTE_UNSIGNED,     32'h43,       32'h0,        32'h80123456, 32'h0,        0, 0, 1, 32'h40,       4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00000080, 3);
        vecs[3]  = mk(1'b1, MEM_WORD,              32'h102,      32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 2, 32'h100,      4'b1100, 32'hBEEF0000, 32'h104,      4'b0011, 32'h0000DEAD, 32'h0,        5);
        vecs[4]  = mk(1'b0, MEM_HALFWORD,          32'hFF,       32'h0,        32'hAB000000, 32'h000000CD, 0, 0, 2, 32'hFC,       4'b1000, 32'h0,        32'h100,      4'b0001, 32'h0,        32'hFFFFCDAB, 5);
        vecs[5]  = mk(1'b0, MEM_WORD,              32'hFFFFFFFE, 32'h0,        32'h11223344, 32'h55667788, 3, 0, 2, 32'hFFFFFFFC, 4'b1100, 32'h0,        32'h00000000, 4'b0011, 32'h0,        32'h77881122, 11);
        vecs[6]  = mk(1'b0, MEM_HALFWORD_UNSIGNED, 32'h2,        32'h0,        32'h87654321, 32'h0,        0, 0, 1, 32'h0,        4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00008765, 3);
        vecs[7]  = mk(1'b0, MEM_HALFWORD,          32'h2,        32'h0,        32'h87654321, 32'h0,        1, 0, 1, 32'h0,        4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF8765, 4);
        vecs[8]  = mk(1'b1, MEM_BYTE,              32'h1001,     32'h123456A5, 32'h0,        32'h0,        0, 0, 1, 32'h1000,     4'b0010, 32'h3456A500, 32'h0,        4'b0000, 32'h0,        32'h0,        3);
        vecs[9]  = mk(1'b1, MEM_HALFWORD,          32'h3,        32'h0000CAFE, 32'h0,        32'h0,        0, 0, 2, 32'h0,        4'b1000, 32'hFE000000, 32'h4,        4'b0001, 32'h000000CA, 32'h0,        5);
        vecs[10] = mk(1'b0, 3'b011,                32'h200,      32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        2);
        vecs[11] = mk(1'b0, MEM_WORD,              32'h8,        32'h0,        32'h0BADF00D, 32'h0,        0, 1, 1, 32'h8,        4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0BADF00D, 3);

        #1 RST_N = 1'b0;
        #2 check_all_zero("reset");
        MEM_Req = 1'b1;
        #1 chk("reset Stall with MEM_Req", 32'(Stall), 32'd0);
        MEM_Req = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // ALLOW_SPLIT=0: an aligned word goes through, then a word at 0x101 is rejected.
        @(negedge CLK); #1;
        MEM_Req2 = 1'b1; MEM_W_En = 1'b0; MEM_Control = MEM_WORD; Addr = 32'h100;
        @(negedge CLK); #1;
        chk("ns aligned BUS_Req", 32'(bus2.BUS_Req), 32'd1);
        bus2.BUS_Ack = 1'b1; bus2.BUS_R_Data = 32'h12345678;
        @(negedge CLK); #1;
        chk("ns aligned Done", 32'(Done2), 32'd1);
        chk("ns aligned R_Data", R_Data2, 32'h12345678);
        MEM_Req2 = 1'b0; bus2.BUS_Ack = 1'b0;
        @(negedge CLK); #1;
        MEM_Req2 = 1'b1; Addr = 32'h101;
        #1 chk("ns split c1 BUS_Req", 32'(bus2.BUS_Req), 32'd0);
        chk("ns split c1 Stall", 32'(Stall2), 32'd1);
        @(negedge CLK); #1;
        chk("ns split Done", 32'(Done2), 32'd1);
        chk("ns split Misaligned", 32'(Misaligned2), 32'd1);
        chk("ns split R_Data", R_Data2, 32'd0);
        chk("ns split BUS_Req", 32'(bus2.BUS_Req), 32'd0);
        chk("ns split Stall", 32'(Stall2), 32'd0);
        MEM_Req2 = 1'b0;
        @(negedge CLK); #1;
        chk("ns split Misaligned pulse", 32'(Misaligned2), 32'd0);

        // Reset while beat 1 is outstanding (responder never acks).
        @(negedge CLK); #1;
        MEM_Req = 1'b1; MEM_W_En = 1'b0; MEM_Control = MEM_WORD; Addr = 32'h20;
        @(negedge CLK); #1;
        chk("midrst BUS_Req before", 32'(bus.BUS_Req), 32'd1);
        RST_N = 1'b0;
        #1 check_all_zero("midrst");
        MEM_Req = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK); #1;
        chk("midrst idle BUS_Req", 32'(bus.BUS_Req), 32'd0);

        run_access(vecs[11]);
        check_vec(12, vecs[11]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
